// File: rtl/flash_adc_pkg.sv
// Shared definitions for the flash ADC back end: comparator-count helper and
// the default resolution used by the ADC top.
package flash_adc_pkg;

  localparam int ADC_N_BITS = 3;

  // Number of comparators needed for an n-bit flash conversion.
  function automatic int therm_w(input int n);
    return (1 << n) - 1;
  endfunction

endpackage

// File: rtl/flash_bubble_corrector.sv
// Combinational 3-input majority bubble filter over a thermometer word, with a
// flag raised whenever the filter altered any bit.
module flash_bubble_corrector #(
  parameter int W = 7
) (
  input  logic [W-1:0] t,
  output logic [W-1:0] c,
  output logic         changed
);

  // Pad with an implied comparator below (always 1) and above (always 0).
  logic [W+1:0] ext;
  assign ext = {1'b0, t, 1'b1};

  for (genvar i = 0; i < W; i++) begin : g_maj
    assign c[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
  end

  assign changed = |(c ^ t);

endmodule

// File: rtl/flash_therm_encoder.sv
// Pipelined thermometer-to-binary encoder: capture, bubble correction, priority
// encode with range flags, plus a saturating count of corrected samples.
module flash_therm_encoder
  import flash_adc_pkg::*;
#(
  parameter int N_BITS = ADC_N_BITS,
  parameter int CNT_W  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [therm_w(N_BITS)-1:0]   therm_in,
  input  logic                         err_clr,
  output logic                         out_valid,
  output logic [N_BITS-1:0]            code_out,
  output logic                         ovr,
  output logic                         udr,
  output logic                         bubble_det,
  output logic [CNT_W-1:0]             err_count
);

  localparam int W = therm_w(N_BITS);

  logic [W-1:0]      t_q;
  logic              v1;
  logic [W-1:0]      c_d;
  logic              chg_d;
  logic [W-1:0]      c_q;
  logic              b2;
  logic              v2;
  logic [N_BITS-1:0] enc;

  // Stage 1: align the raw comparator word to the sampling clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q <= '0;
      v1  <= 1'b0;
    end else begin
      v1 <= in_valid;
      if (in_valid) t_q <= therm_in;
    end
  end

  flash_bubble_corrector #(.W(W)) u_corr (
    .t       (t_q),
    .c       (c_d),
    .changed (chg_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q <= '0;
      b2  <= 1'b0;
      v2  <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        c_q <= c_d;
        b2  <= chg_d;
      end
    end
  end

  // Highest set bit wins, so leftover sparkles resolve to the top-most one.
  always_comb begin
    enc = '0;
    for (int i = 0; i < W; i++) begin
      if (c_q[i]) enc = N_BITS'(i + 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      code_out   <= '0;
      ovr        <= 1'b0;
      udr        <= 1'b0;
      bubble_det <= 1'b0;
    end else begin
      out_valid <= v2;
      if (v2) begin
        code_out   <= enc;
        ovr        <= &c_q;
        udr        <= ~|c_q;
        bubble_det <= b2;
      end
    end
  end

  // Clear beats a coincident increment; the count sticks at all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (out_valid && bubble_det && (err_count != '1)) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_flash_therm_encoder.sv
// Self-checking bench for flash_therm_encoder (N_BITS=3, CNT_W=4) against a
// sample-level reference model of correction, encoding and error counting.
module tb_flash_therm_encoder;

  localparam int N_BITS  = 3;
  localparam int W       = 7;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;
  localparam logic [W-1:0] SPARKLE = 7'b0100111;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [W-1:0]      therm_in = '0;
  logic              err_clr = 1'b0;
  logic              out_valid;
  logic [N_BITS-1:0] code_out;
  logic              ovr;
  logic              udr;
  logic              bubble_det;
  logic [CNT_W-1:0]  err_count;

  flash_therm_encoder #(.N_BITS(N_BITS), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .therm_in   (therm_in),
    .err_clr    (err_clr),
    .out_valid  (out_valid),
    .code_out   (code_out),
    .ovr        (ovr),
    .udr        (udr),
    .bubble_det (bubble_det),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic         v;
    logic [W-1:0] t;
  } sample_t;

  sample_t pend[$];
  logic    m_valid;
  int      m_code;
  logic    m_ovr;
  logic    m_udr;
  logic    m_bub;
  int      m_cnt;

  function automatic logic [W-1:0] correct(input logic [W-1:0] t);
    logic [W-1:0] r;
    int votes;
    for (int i = 0; i < W; i++) begin
      votes = int'(t[i]);
      votes += (i == 0) ? 1 : int'(t[i-1]);
      votes += (i == W - 1) ? 0 : int'(t[i+1]);
      r[i] = (votes >= 2);
    end
    return r;
  endfunction

  function automatic int encode(input logic [W-1:0] c);
    int code = 0;
    for (int i = 0; i < W; i++) if (c[i]) code = i + 1;
    return code;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    pend.delete();
    m_valid = 1'b0;
    m_code  = 0;
    m_ovr   = 1'b0;
    m_udr   = 1'b0;
    m_bub   = 1'b0;
    m_cnt   = 0;
  endtask

  // One rising edge: counter sees the outputs as they were before the edge.
  task automatic modelStep(input logic v, input logic [W-1:0] t, input logic clr);
    sample_t s;
    logic [W-1:0] c;
    if (clr) m_cnt = 0;
    else if (m_valid && m_bub && m_cnt < CNT_MAX) m_cnt++;
    s.v = v;
    s.t = t;
    pend.push_back(s);
    if (pend.size() > 2) begin
      s = pend.pop_front();
      m_valid = s.v;
      if (s.v) begin
        c      = correct(s.t);
        m_code = encode(c);
        m_ovr  = (c == {W{1'b1}});
        m_udr  = (c == '0);
        m_bub  = (c != s.t);
      end
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [W-1:0] t, input logic clr);
    @(negedge clk);
    in_valid = v;
    therm_in = t;
    err_clr  = clr;
    @(posedge clk);
    modelStep(v, t, clr);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".out_valid"}, out_valid, m_valid);
    check({tag, ".code_out"}, code_out, m_code);
    check({tag, ".ovr"}, ovr, m_ovr);
    check({tag, ".udr"}, udr, m_udr);
    check({tag, ".bubble_det"}, bubble_det, m_bub);
    check({tag, ".err_count"}, err_count, m_cnt);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, ".out_valid"}, out_valid, 0);
    check({tag, ".code_out"}, code_out, 0);
    check({tag, ".ovr"}, ovr, 0);
    check({tag, ".udr"}, udr, 0);
    check({tag, ".bubble_det"}, bubble_det, 0);
    check({tag, ".err_count"}, err_count, 0);
  endtask

  initial begin
    logic [7:0] ones;
    logic [W-1:0] rt;
    logic rv, rc;

    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Two samples in flight when reset hits: neither may emerge.
    applyStimulus(1'b1, 7'b0001111, 1'b0);
    applyStimulus(1'b1, SPARKLE, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    modelReset();
    checkAllZero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 7'h7F, 1'b0);
      checkAllZero("postreset");
    end

    // Clean sweep of 0..7 ones, back to back.
    for (int k = 0; k < 10; k++) begin
      ones = (8'd1 << ((k < 8) ? k : 0)) - 8'd1;
      applyStimulus(k < 8, ones[W-1:0], 1'b0);
      checkOutput("sweep");
      if (k >= 2) begin
        check("sweep.const_valid", out_valid, 1);
        check("sweep.const_code", code_out, k - 2);
      end
    end

    applyStimulus(1'b1, 7'b0001111, 1'b0);
    applyStimulus(1'b1, 7'h7F, 1'b0);
    applyStimulus(1'b1, 7'h00, 1'b0);
    checkOutput("clean4");
    check("clean4.code", code_out, 4);
    check("clean4.bub", bubble_det, 0);
    applyStimulus(1'b1, 7'b0001011, 1'b0);
    checkOutput("full");
    check("full.code", code_out, 7);
    check("full.ovr", ovr, 1);
    applyStimulus(1'b1, SPARKLE, 1'b0);
    checkOutput("empty");
    check("empty.udr", udr, 1);
    check("empty.bub", bubble_det, 0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("bubble");
    check("bubble.bub", bubble_det, 1);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("sparkle");
    check("sparkle.code", code_out, 3);
    check("sparkle.bub", bubble_det, 1);

    // Saturation, then a clear coinciding with a bubbly output sample.
    applyStimulus(1'b0, '0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, SPARKLE, 1'b0);
      checkOutput("sat");
    end
    repeat (3) applyStimulus(1'b0, '0, 1'b0);
    checkOutput("sat.end");
    check("sat.const", err_count, CNT_MAX);
    applyStimulus(1'b1, SPARKLE, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    check("clr.bubbly_valid", out_valid & bubble_det, 1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("clr");
    check("clr.const", err_count, 0);

    // Gapped input 1,0,1 with junk on the gap.
    applyStimulus(1'b1, 7'b0000011, 1'b0);
    applyStimulus(1'b0, 7'h7F, 1'b0);
    applyStimulus(1'b1, 7'b0011111, 1'b0);
    checkOutput("gap0");
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("gap1");
    check("gap1.hold", code_out, 2);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("gap2");
    check("gap2.code", code_out, 5);

    // Random thermometer words with occasional bit flips and clears.
    for (int k = 0; k < 200; k++) begin
      ones = (8'd1 << $urandom_range(0, 7)) - 8'd1;
      rt = ones[W-1:0];
      if ($urandom_range(0, 2) == 0) rt[$urandom_range(0, W - 1)] ^= 1'b1;
      if ($urandom_range(0, 7) == 0) rt = W'($urandom);
      rv = ($urandom_range(0, 3) != 0);
      rc = ($urandom_range(0, 15) == 0);
      applyStimulus(rv, rt, rc);
      checkOutput("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
